// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
// ----------------
// Multi-cycle control unit for a small MIPS-like datapath. A Moore FSM walks
// each instruction through FETCH, DECODE, EXEC, MEM, WB and NEXTPC. Every
// output comes straight from a flop. Each output flop is loaded with the value
// that belongs to the state being entered, so a strobe is high for exactly the
// cycles spent in its state.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 asynchronous active-high reset
//   run                 level; high permits leaving IDLE / starting next fetch
//   opcode, funct       instruction[31:26] and instruction[5:0]
//   out_alu             ALU result (zero test for BEQ)
//   is_load_PC          one-cycle PC load strobe (NEXTPC)
//   is_write_reg        one-cycle register-file write strobe (WB)
//   is_write_mem        one-cycle data-memory write strobe (MEM of SW)
//   is_write_from_mem   register write data comes from memory (LW)
//   is_R_type/I/J       instruction-format selects, at most one high
//   opcode_alu          ALU op: ADD=0 SUB=1 AND=2 OR=3 SLT=4
//   control_mux_for_PC  next-PC select (PC_SEL_INC / _BR / _JMP)
//   state               current FSM state code
//   halted              FSM is in the absorbing HALT state
//   illegal             sticky flag: an illegal instruction was decoded
//   retired             retired-instruction counter (wraps)
module cpu_control_fsm #(
  parameter logic [1:0] PC_SEL_INC = 2'd0,
  parameter logic [1:0] PC_SEL_BR  = 2'd1,
  parameter logic [1:0] PC_SEL_JMP = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] out_alu,
  output logic        is_load_PC,
  output logic        is_write_reg,
  output logic        is_write_mem,
  output logic        is_write_from_mem,
  output logic        is_R_type,
  output logic        is_I_type,
  output logic        is_J_type,
  output logic [5:0]  opcode_alu,
  output logic [1:0]  control_mux_for_PC,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_NEXTPC = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Decoded instruction class; latched at DECODE so later states do not
  // depend on the instruction bus staying stable.
  typedef enum logic [3:0] {
    I_ILL, I_ADD, I_SUB, I_AND, I_OR, I_SLT,
    I_ADDI, I_ANDI, I_ORI, I_LW, I_SW, I_BEQ, I_J, I_HALT
  } instr_t;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_SLT = 6'd4;

  function automatic instr_t decode(input logic [5:0] op, input logic [5:0] fn);
    instr_t d;
    d = I_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: d = I_ADD;
          6'b100010: d = I_SUB;
          6'b100100: d = I_AND;
          6'b100101: d = I_OR;
          6'b101010: d = I_SLT;
          default:   d = I_ILL;
        endcase
      end
      6'b001000: d = I_ADDI;
      6'b001100: d = I_ANDI;
      6'b001101: d = I_ORI;
      6'b100011: d = I_LW;
      6'b101011: d = I_SW;
      6'b000100: d = I_BEQ;
      6'b000010: d = I_J;
      6'b111111: d = I_HALT;
      default:   d = I_ILL;
    endcase
    return d;
  endfunction

  state_t      state_reg, state_next;
  instr_t      instr_reg, instr_next;
  instr_t      dec_instr;
  logic        taken_reg, taken_next;
  logic        illegal_reg, illegal_next;
  logic [31:0] retired_reg, retired_next;
  logic [2:0]  type_reg, type_next;          // {R, I, J}
  logic [5:0]  alu_reg, alu_next;
  logic        wfm_reg, wfm_next;
  logic        load_pc_reg, load_pc_next;
  logic        write_reg_reg, write_reg_next;
  logic        write_mem_reg, write_mem_next;
  logic [1:0]  sel_reg, sel_next;
  logic        halted_reg, halted_next;

  assign dec_instr = decode(opcode, funct);

  always_comb begin
    state_next   = state_reg;
    instr_next   = instr_reg;
    taken_next   = taken_reg;
    illegal_next = illegal_reg;
    retired_next = retired_reg;
    type_next    = type_reg;
    alu_next     = alu_reg;
    wfm_next     = wfm_reg;

    case (state_reg)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        instr_next = dec_instr;
        taken_next = 1'b0;
        type_next  = 3'b000;
        alu_next   = ALU_ADD;
        case (dec_instr)
          I_HALT: state_next = S_HALT;
          I_J: begin
            state_next = S_NEXTPC;
            type_next  = 3'b001;
          end
          I_ILL: begin
            state_next   = S_NEXTPC;
            illegal_next = 1'b1;
          end
          default: state_next = S_EXEC;
        endcase
        case (dec_instr)
          I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_BEQ: type_next = 3'b100;
          I_ADDI, I_ANDI, I_ORI, I_LW, I_SW:       type_next = 3'b010;
          default: ;
        endcase
        case (dec_instr)
          I_SUB, I_BEQ:  alu_next = ALU_SUB;
          I_AND, I_ANDI: alu_next = ALU_AND;
          I_OR, I_ORI:   alu_next = ALU_OR;
          I_SLT:         alu_next = ALU_SLT;
          default:       alu_next = ALU_ADD;
        endcase
      end
      S_EXEC: begin
        case (instr_reg)
          I_LW: begin
            state_next = S_MEM;
            wfm_next   = 1'b1;
          end
          I_SW:  state_next = S_MEM;
          I_BEQ: begin
            state_next = S_NEXTPC;
            taken_next = (out_alu == 32'd0);
          end
          default: state_next = S_WB;
        endcase
      end
      S_MEM:    state_next = (instr_reg == I_LW) ? S_WB : S_NEXTPC;
      S_WB:     state_next = S_NEXTPC;
      S_NEXTPC: begin
        state_next   = run ? S_FETCH : S_IDLE;
        retired_next = retired_reg + 32'd1;
        type_next    = 3'b000;
        alu_next     = ALU_ADD;
        wfm_next     = 1'b0;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase

    // Strobes are registered copies of "the state being entered".
    load_pc_next   = (state_next == S_NEXTPC);
    write_reg_next = (state_next == S_WB);
    write_mem_next = (state_next == S_MEM) && (instr_next == I_SW);
    halted_next    = (state_next == S_HALT);
    sel_next       = PC_SEL_INC;
    if (state_next == S_NEXTPC) begin
      if (instr_next == I_J)
        sel_next = PC_SEL_JMP;
      else if (instr_next == I_BEQ && taken_next)
        sel_next = PC_SEL_BR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      instr_reg     <= I_ILL;
      taken_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      retired_reg   <= 32'd0;
      type_reg      <= 3'b000;
      alu_reg       <= ALU_ADD;
      wfm_reg       <= 1'b0;
      load_pc_reg   <= 1'b0;
      write_reg_reg <= 1'b0;
      write_mem_reg <= 1'b0;
      sel_reg       <= PC_SEL_INC;
      halted_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      instr_reg     <= instr_next;
      taken_reg     <= taken_next;
      illegal_reg   <= illegal_next;
      retired_reg   <= retired_next;
      type_reg      <= type_next;
      alu_reg       <= alu_next;
      wfm_reg       <= wfm_next;
      load_pc_reg   <= load_pc_next;
      write_reg_reg <= write_reg_next;
      write_mem_reg <= write_mem_next;
      sel_reg       <= sel_next;
      halted_reg    <= halted_next;
    end
  end

  assign state              = state_reg;
  assign is_load_PC         = load_pc_reg;
  assign is_write_reg       = write_reg_reg;
  assign is_write_mem       = write_mem_reg;
  assign is_write_from_mem  = wfm_reg;
  assign is_R_type          = type_reg[2];
  assign is_I_type          = type_reg[1];
  assign is_J_type          = type_reg[0];
  assign opcode_alu         = alu_reg;
  assign control_mux_for_PC = sel_reg;
  assign halted             = halted_reg;
  assign illegal            = illegal_reg;
  assign retired            = retired_reg;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed testbench for cpu_control_fsm: one task per scenario, each with
// hand-computed expected values and inline comparisons.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] out_alu = 32'd0;
  logic        is_load_PC, is_write_reg, is_write_mem, is_write_from_mem;
  logic        is_R_type, is_I_type, is_J_type;
  logic [5:0]  opcode_alu;
  logic [1:0]  control_mux_for_PC;
  logic [2:0]  state;
  logic        halted, illegal;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instruction trace, cycle 0 = FETCH.
  int          tr_n;
  logic [35:0] st_seq;
  logic [11:0] m_wr, m_wm, m_wfm, m_ld;
  logic [2:0]  tr_typ [12];
  logic [5:0]  tr_alu [12];
  logic [1:0]  tr_sel [12];
  logic [31:0] exp_ret = 32'd0;
  logic [31:0] exp_np;

  cpu_control_fsm dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .out_alu(out_alu), .is_load_PC(is_load_PC), .is_write_reg(is_write_reg),
    .is_write_mem(is_write_mem), .is_write_from_mem(is_write_from_mem),
    .is_R_type(is_R_type), .is_I_type(is_I_type), .is_J_type(is_J_type),
    .opcode_alu(opcode_alu), .control_mux_for_PC(control_mux_for_PC),
    .state(state), .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from IDLE or NEXTPC until NEXTPC is observed.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] alu, input bit drop_run);
    opcode = op; funct = fn; out_alu = alu; run = 1'b1;
    tr_n = 0; st_seq = '0; m_wr = '0; m_wm = '0; m_wfm = '0; m_ld = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (drop_run && c == 0) run = 1'b0;
      st_seq[3*c +: 3] = state;
      m_wr[c] = is_write_reg; m_wm[c] = is_write_mem;
      m_wfm[c] = is_write_from_mem; m_ld[c] = is_load_PC;
      tr_typ[c] = {is_R_type, is_I_type, is_J_type};
      tr_alu[c] = opcode_alu; tr_sel[c] = control_mux_for_PC;
      tr_n++;
      if (state === 3'd6) break;
    end
    if (state !== 3'd6) begin
      n_cmp++; n_bad++;
      $display("FAIL instr_timeout op=%h state=%0d required=6", op, state);
    end
    exp_np = exp_ret;
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d required=0", state); end
    n_cmp++;
    if ({is_load_PC, is_write_reg, is_write_mem, is_write_from_mem, is_R_type, is_I_type, is_J_type} !== 7'd0) begin
      n_bad++; $display("FAIL reset_strobes got=%b required=0", {is_load_PC, is_write_reg, is_write_mem, is_write_from_mem, is_R_type, is_I_type, is_J_type});
    end
    n_cmp++;
    if ({opcode_alu, control_mux_for_PC, halted, illegal} !== 10'd0) begin
      n_bad++; $display("FAIL reset_misc got=%b required=0", {opcode_alu, control_mux_for_PC, halted, illegal});
    end
    n_cmp++; if (retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired got=%0d required=0", retired); end
    run = 1'b1;
    step(); step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_held_state got=%0d required=0", state); end
    rst = 1'b0; run = 1'b0;
    step(); step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_no_run got=%0d required=0", state); end
    $display("reset: done");
  endtask

  task automatic test_add();
    run_instr(6'h00, 6'h20, 32'd7, 1'b0);
    n_cmp++; if (tr_n !== 5) begin n_bad++; $display("FAIL add_cycles got=%0d required=5", tr_n); end
    n_cmp++; if (st_seq !== {21'd0, 3'd6, 3'd5, 3'd3, 3'd2, 3'd1}) begin n_bad++; $display("FAIL add_states got=%h", st_seq); end
    n_cmp++; if (m_wr !== 12'h008) begin n_bad++; $display("FAIL add_write_reg got=%h required=008", m_wr); end
    n_cmp++; if (m_ld !== 12'h010) begin n_bad++; $display("FAIL add_load_pc got=%h required=010", m_ld); end
    n_cmp++; if (tr_sel[4] !== 2'd0) begin n_bad++; $display("FAIL add_sel got=%0d required=0", tr_sel[4]); end
    n_cmp++;
    if ({tr_typ[1], tr_typ[2], tr_typ[3], tr_typ[4]} !== 12'b000_100_100_100) begin
      n_bad++; $display("FAIL add_type got=%b", {tr_typ[1], tr_typ[2], tr_typ[3], tr_typ[4]});
    end
    n_cmp++; if (retired !== exp_np) begin n_bad++; $display("FAIL add_retired_np got=%0d required=%0d", retired, exp_np); end
    run = 1'b0;
    step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL add_to_idle got=%0d required=0", state); end
    n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL add_retired got=%0d required=%0d", retired, exp_ret); end
    n_cmp++; if ({is_R_type, is_I_type, is_J_type} !== 3'b000) begin n_bad++; $display("FAIL add_type_clear got=%b", {is_R_type, is_I_type, is_J_type}); end
    $display("add: cycles=%0d retired=%0d", tr_n, retired);
  endtask

  task automatic test_lw();
    run_instr(6'h23, 6'h00, 32'd0, 1'b0);
    n_cmp++; if (tr_n !== 6) begin n_bad++; $display("FAIL lw_cycles got=%0d required=6", tr_n); end
    n_cmp++; if (st_seq !== {18'd0, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}) begin n_bad++; $display("FAIL lw_states got=%h", st_seq); end
    n_cmp++; if (m_wm !== 12'h000) begin n_bad++; $display("FAIL lw_write_mem got=%h required=000", m_wm); end
    n_cmp++; if (m_wfm !== 12'h038) begin n_bad++; $display("FAIL lw_from_mem got=%h required=038", m_wfm); end
    n_cmp++; if (m_wr !== 12'h010) begin n_bad++; $display("FAIL lw_write_reg got=%h required=010", m_wr); end
    n_cmp++; if ({tr_typ[2], tr_alu[2]} !== {3'b010, 6'd0}) begin n_bad++; $display("FAIL lw_type_alu got=%b/%0d", tr_typ[2], tr_alu[2]); end
    $display("lw: cycles=%0d", tr_n);
  endtask

  task automatic test_sw();
    run_instr(6'h2B, 6'h00, 32'd0, 1'b0);
    n_cmp++; if (tr_n !== 5) begin n_bad++; $display("FAIL sw_cycles got=%0d required=5", tr_n); end
    n_cmp++; if (st_seq !== {21'd0, 3'd6, 3'd4, 3'd3, 3'd2, 3'd1}) begin n_bad++; $display("FAIL sw_states got=%h", st_seq); end
    n_cmp++; if (m_wm !== 12'h008) begin n_bad++; $display("FAIL sw_write_mem got=%h required=008", m_wm); end
    n_cmp++; if ({m_wr, m_wfm} !== 24'd0) begin n_bad++; $display("FAIL sw_no_reg_write got=%h/%h", m_wr, m_wfm); end
    n_cmp++; if (tr_typ[3] !== 3'b010) begin n_bad++; $display("FAIL sw_type got=%b required=010", tr_typ[3]); end
    n_cmp++; if (retired !== exp_np) begin n_bad++; $display("FAIL sw_retired got=%0d required=%0d", retired, exp_np); end
    $display("sw: cycles=%0d", tr_n);
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'h00, 32'd0, 1'b0);
    n_cmp++; if (tr_n !== 4) begin n_bad++; $display("FAIL beq_cycles got=%0d required=4", tr_n); end
    n_cmp++; if (st_seq !== {24'd0, 3'd6, 3'd3, 3'd2, 3'd1}) begin n_bad++; $display("FAIL beq_states got=%h", st_seq); end
    n_cmp++; if (tr_sel[3] !== 2'd1) begin n_bad++; $display("FAIL beq_taken_sel got=%0d required=1", tr_sel[3]); end
    n_cmp++; if ({tr_alu[2], tr_typ[3]} !== {6'd1, 3'b100}) begin n_bad++; $display("FAIL beq_alu_type got=%0d/%b", tr_alu[2], tr_typ[3]); end
    run_instr(6'h04, 6'h00, 32'd5, 1'b0);
    n_cmp++; if (tr_sel[3] !== 2'd0) begin n_bad++; $display("FAIL beq_not_taken_sel got=%0d required=0", tr_sel[3]); end
    n_cmp++; if (tr_alu[2] !== 6'd1) begin n_bad++; $display("FAIL beq2_alu got=%0d required=1", tr_alu[2]); end
    n_cmp++; if (retired !== exp_np) begin n_bad++; $display("FAIL beq_retired got=%0d required=%0d", retired, exp_np); end
    $display("beq: taken and not-taken done");
  endtask

  task automatic test_j();
    run_instr(6'h02, 6'h00, 32'd0, 1'b0);
    n_cmp++; if (tr_n !== 3) begin n_bad++; $display("FAIL j_cycles got=%0d required=3", tr_n); end
    n_cmp++; if (st_seq !== {27'd0, 3'd6, 3'd2, 3'd1}) begin n_bad++; $display("FAIL j_states got=%h", st_seq); end
    n_cmp++; if (tr_sel[2] !== 2'd2) begin n_bad++; $display("FAIL j_sel got=%0d required=2", tr_sel[2]); end
    n_cmp++; if ({tr_typ[2], tr_alu[2]} !== {3'b001, 6'd0}) begin n_bad++; $display("FAIL j_type_alu got=%b/%0d", tr_typ[2], tr_alu[2]); end
    $display("j: cycles=%0d", tr_n);
  endtask

  task automatic test_alu_ops();
    logic [5:0] ops   [7] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D};
    logic [5:0] fns   [7] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h00};
    logic [5:0] alus  [7] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd0, 6'd2, 6'd3};
    logic [2:0] types [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b010};
    for (int k = 0; k < 7; k++) begin
      run_instr(ops[k], fns[k], 32'd1, 1'b0);
      n_cmp++; if (tr_n !== 5) begin n_bad++; $display("FAIL alu_cycles[%0d] got=%0d required=5", k, tr_n); end
      n_cmp++;
      if (tr_alu[2] !== alus[k] || tr_alu[4] !== alus[k]) begin
        n_bad++; $display("FAIL alu_op[%0d] got=%0d/%0d required=%0d", k, tr_alu[2], tr_alu[4], alus[k]);
      end
      n_cmp++; if (tr_typ[4] !== types[k]) begin n_bad++; $display("FAIL alu_type[%0d] got=%b required=%b", k, tr_typ[4], types[k]); end
      $display("alu_op[%0d]: op=%h funct=%h alu=%0d", k, ops[k], fns[k], tr_alu[2]);
    end
  endtask

  task automatic test_illegal();
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_pre got=%b required=0", illegal); end
    run_instr(6'h15, 6'h00, 32'd0, 1'b0);
    n_cmp++; if (tr_n !== 3) begin n_bad++; $display("FAIL illegal_cycles got=%0d required=3", tr_n); end
    n_cmp++; if ({illegal, tr_sel[2], tr_typ[2]} !== {1'b1, 2'd0, 3'b000}) begin n_bad++; $display("FAIL illegal_flags got=%b/%0d/%b", illegal, tr_sel[2], tr_typ[2]); end
    run_instr(6'h00, 6'h21, 32'd0, 1'b0);
    n_cmp++; if (tr_n !== 3) begin n_bad++; $display("FAIL illegal_funct_cycles got=%0d required=3", tr_n); end
    run_instr(6'h00, 6'h20, 32'd0, 1'b0);
    n_cmp++; if (tr_n !== 5 || illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky cycles=%0d illegal=%b", tr_n, illegal); end
    run = 1'b0;
    step();
    n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL illegal_retired got=%0d required=%0d", retired, exp_ret); end
    $display("illegal: retired=%0d illegal=%b", retired, illegal);
  endtask

  task automatic test_run_drop();
    run_instr(6'h00, 6'h20, 32'd0, 1'b1);
    n_cmp++; if (tr_n !== 5) begin n_bad++; $display("FAIL run_drop_cycles got=%0d required=5", tr_n); end
    step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL run_drop_idle got=%0d required=0", state); end
    $display("run_drop: cycles=%0d", tr_n);
  endtask

  task automatic test_halt();
    bit bad = 1'b0;
    opcode = 6'h3F; funct = 6'h00; run = 1'b1;
    step(); step(); step();
    n_cmp++; if ({state, halted} !== {3'd7, 1'b1}) begin n_bad++; $display("FAIL halt_enter got=%0d/%b", state, halted); end
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      opcode = 6'h20;
      step();
      if (state !== 3'd7 || halted !== 1'b1 ||
          {is_load_PC, is_write_reg, is_write_mem, is_write_from_mem} !== 4'd0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL halt_absorb state=%0d halted=%b", state, halted); end
    #2 rst = 1'b1;
    #1;
    exp_ret = 32'd0;
    n_cmp++; if ({state, halted, illegal} !== 5'd0) begin n_bad++; $display("FAIL halt_reset got=%0d/%b/%b", state, halted, illegal); end
    n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL halt_reset_retired got=%0d required=0", retired); end
    step();
    rst = 1'b0; run = 1'b0;
    $display("halt: absorbed and reset");
  endtask

  task automatic test_sw_reset();
    opcode = 6'h2B; funct = 6'h00; run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (state === 3'd4) break;
    end
    n_cmp++; if ({state, is_write_mem} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL sw_mem_reach got=%0d/%b", state, is_write_mem); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({is_write_mem, is_write_reg, is_load_PC} !== 3'd0 || state !== 3'd0) begin
      n_bad++; $display("FAIL sw_async_reset strobes=%b state=%0d", {is_write_mem, is_write_reg, is_load_PC}, state);
    end
    n_cmp++; if (retired !== exp_ret) begin n_bad++; $display("FAIL sw_reset_retired got=%0d required=%0d", retired, exp_ret); end
    step();
    rst = 1'b0; run = 1'b0;
    step(); step(); step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL sw_reset_idle got=%0d required=0", state); end
    $display("sw_reset: state=%0d", state);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_beq();
    test_j();
    test_alu_ops();
    test_illegal();
    test_run_drop();
    test_halt();
    test_sw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
